pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Owns the 12-bit program counter and sequences instruction flow: fetch handshake, next-PC select
//  (increment, skip, jump, resume), and optional interrupt vectoring with return-address save.
//  Sits between the instruction memory port and the execute/decode logic.
// PARAMETERS
//  ADDR_W        12      PC / fetch address width; all PC arithmetic is modulo 2**ADDR_W
//  RESET_VEC     12'h800 PC value on reset (fresh-start address)
//  INT_VEC_BASE  12'h804 vector for int_id=0; vector = INT_VEC_BASE + 4*int_id
// PORTS
//  clk          in   1       clock, all state updates on posedge
//  rst_n        in   1       asynchronous, active-low reset
//  run          in   1       1 = sequencing allowed
//  fetch_req    out  1       fetch request, held high until fetch_ack
//  fetch_addr   out  ADDR_W  address being fetched (== pc while in FETCH)
//  fetch_ack    in   1       memory accepted/returned fetch; honoured only in FETCH
//  instr_valid  out  1       1-cycle pulse: fetched word valid, EXEC entered
//  exec_done    in   1       execute finished; honoured only in EXEC
//  pc_op        in   2       00 NEXT(+1), 01 SKIP1(+2), 10 SKIP2(+3), 11 JUMP(jump_addr)
//  jump_addr    in   ADDR_W  target for JUMP
//  resume       in   1       with exec_done: return from interrupt, overrides pc_op
//  int_req      in   1       level interrupt request
//  int_id       in   3       vector index, sampled in INTSVC
//  int_ack      out  1       1-cycle pulse in INTSVC
//  int_active   out  1       1 while servicing an interrupt
//  ret_addr     out  ADDR_W  saved return PC
//  pc           out  ADDR_W  current PC
//  state        out  2       IDLE=0 FETCH=1 EXEC=2 INTSVC=3
// BEHAVIOUR
//  Reset (rst_n=0, async): pc=RESET_VEC, state=IDLE, ret_addr=0, all 1-bit outputs 0.
//  IDLE: run=1 -> FETCH next cycle; otherwise hold.
//  FETCH: fetch_req=1, fetch_addr=pc; on fetch_ack -> EXEC, instr_valid=1 for that one cycle.
//   run dropping mid-FETCH does not abort; fetch completes normally.
//  EXEC: wait for exec_done; on the exec_done edge pc <= next PC per pc_op (or ret_addr if resume,
//   clearing int_active). Next state: INTSVC if int_req & !int_active; else FETCH if run; else IDLE.
//  INTSVC (1 cycle): ret_addr<=pc, pc<=INT_VEC_BASE+4*int_id, int_active<=1, int_ack=1 -> FETCH.
//  Interrupts sampled only at exec_done (instruction boundary); no nesting while int_active.
//  Wrap: 0xFFF+1=0x000, 0xFFE+3=0x001; JUMP unaffected. resume with int_active=0: pc<=ret_addr anyway.
//  fetch_ack outside FETCH and exec_done outside EXEC are ignored. Fetch latency >= 1 cycle.
// CONFIGURATION
//  PC_SEQ_INTR_EN defined: interrupt logic as above.
//  Undefined: INTSVC unreachable, int_req/int_id/resume ignored, int_ack=int_active=0, ret_addr=0.
// STRUCTURE
//  pc_seq_pkg: state encoding, pc_op encoding (OP_NEXT..OP_JUMP), default ADDR_W/RESET_VEC.
//  Sub-module pc_next_calc: combinational next-PC mux/adder (pc, pc_op, jump_addr, resume, ret_addr).
// TESTING
//  1 reset; run=1 -> cycle after: state=FETCH, fetch_req=1, fetch_addr=0x800.
//  2 fetch_ack after 3 cycles -> instr_valid 1 cycle; exec_done NEXT -> pc=0x801; SKIP2 -> 0x804.
//  3 JUMP jump_addr=0xAAA -> fetch_addr=0xAAA; at pc=0xFFF NEXT -> 0x000; SKIP1 at 0xFFF -> 0x001.
//  4 pc=0x810, int_req=1 int_id=2, exec_done NEXT -> INTSVC, int_ack pulse, ret_addr=0x811,
//    fetch_addr=0x80C; 2nd int_req ignored; resume -> pc=0x811, int_active=0.
//  5 rst_n low mid-FETCH (no ack) -> immediately pc=0x800, fetch_req=0, state=IDLE.
//  6 run=0 during FETCH -> fetch completes, EXEC completes, then IDLE; macro off: int_req never acked.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared encodings and default sizing for the program-counter sequencer.
package pc_seq_pkg;

    localparam int          ADDR_W_DEF       = 12;
    localparam logic [11:0] RESET_VEC_DEF    = 12'h800;
    localparam logic [11:0] INT_VEC_BASE_DEF = 12'h804;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_INTSVC = 2'd3
    } seq_state_e;

    typedef enum logic [1:0] {
        OP_NEXT  = 2'd0,
        OP_SKIP1 = 2'd1,
        OP_SKIP2 = 2'd2,
        OP_JUMP  = 2'd3
    } pc_op_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch / execute / interrupt bundle between the sequencer (master) and its surroundings (slave).
interface pc_seq_if #(parameter int ADDR_W = pc_seq_pkg::ADDR_W_DEF);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ack;
    logic              instr_valid;
    logic              exec_done;
    logic [1:0]        pc_op;
    logic [ADDR_W-1:0] jump_addr;
    logic              resume;
    logic              int_req;
    logic [2:0]        int_id;
    logic              int_ack;
    logic              int_active;
    logic [ADDR_W-1:0] ret_addr;
    logic [ADDR_W-1:0] pc;
    logic [1:0]        state;

    modport master (
        output fetch_req, fetch_addr, instr_valid, int_ack, int_active, ret_addr, pc, state,
        input  fetch_ack, exec_done, pc_op, jump_addr, resume, int_req, int_id
    );

    modport slave (
        input  fetch_req, fetch_addr, instr_valid, int_ack, int_active, ret_addr, pc, state,
        output fetch_ack, exec_done, pc_op, jump_addr, resume, int_req, int_id
    );
endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC select: increment/skip (modulo 2**ADDR_W), jump, or return from interrupt.
module pc_next_calc
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] pc,
    input  pc_op_e            op,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              resume,
    input  logic [ADDR_W-1:0] ret_addr,
    output logic [ADDR_W-1:0] next_pc
);

    always_comb begin
        next_pc = pc + ADDR_W'(1);
        if (resume) begin
            next_pc = ret_addr;
        end else begin
            case (op)
                OP_NEXT:  next_pc = pc + ADDR_W'(1);
                OP_SKIP1: next_pc = pc + ADDR_W'(2);
                OP_SKIP2: next_pc = pc + ADDR_W'(3);
                OP_JUMP:  next_pc = jump_addr;
                default:  next_pc = pc + ADDR_W'(1);
            endcase
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch handshake, next-PC update at instruction boundaries, and
// interrupt vectoring with return-address save when PC_SEQ_INTR_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | halted, waiting for run
// ST_FETCH  | fetch_req high at fetch_addr=pc until fetch_ack
// ST_EXEC   | instruction executing; pc advances on exec_done
// ST_INTSVC | one cycle: save return pc, load vector, raise int_active
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W       = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_VEC    = ADDR_W'(RESET_VEC_DEF),
    parameter logic [ADDR_W-1:0] INT_VEC_BASE = ADDR_W'(INT_VEC_BASE_DEF)
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      run,
    pc_seq_if.master  bus
);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ret_q, ret_d;
    logic              int_act_q, int_act_d;
    logic              ivalid_q, ivalid_d;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] vec_addr;
    logic              take_int;
    logic              resume_eff;

`ifdef PC_SEQ_INTR_EN
    assign resume_eff = bus.resume;
    // Nesting check uses the pre-resume int_active so a lingering request cannot re-enter at return.
    assign take_int   = bus.int_req & ~int_act_q;
    assign vec_addr   = INT_VEC_BASE + ADDR_W'({bus.int_id, 2'b00});
`else
    logic unused_intr;
    assign unused_intr = ^{bus.int_req, bus.int_id, bus.resume};
    assign resume_eff  = 1'b0;
    assign take_int    = 1'b0;
    assign vec_addr    = INT_VEC_BASE;
`endif

    pc_next_calc #(.ADDR_W(ADDR_W)) u_next (
        .pc        (pc_q),
        .op        (pc_op_e'(bus.pc_op)),
        .jump_addr (bus.jump_addr),
        .resume    (resume_eff),
        .ret_addr  (ret_q),
        .next_pc   (next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_VEC;
            ret_q     <= '0;
            int_act_q <= 1'b0;
            ivalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ret_q     <= ret_d;
            int_act_q <= int_act_d;
            ivalid_q  <= ivalid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ret_d     = ret_q;
        int_act_d = int_act_q;
        ivalid_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.fetch_ack) begin
                    state_d  = ST_EXEC;
                    ivalid_d = 1'b1;
                end
            end
            ST_EXEC: begin
                if (bus.exec_done) begin
                    pc_d = next_pc;
                    if (resume_eff) int_act_d = 1'b0;
                    if (take_int)   state_d = ST_INTSVC;
                    else if (run)   state_d = ST_FETCH;
                    else            state_d = ST_IDLE;
                end
            end
            ST_INTSVC: begin
                ret_d     = pc_q;
                pc_d      = vec_addr;
                int_act_d = 1'b1;
                state_d   = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.fetch_req   = (state_q == ST_FETCH);
    assign bus.fetch_addr  = pc_q;
    assign bus.instr_valid = ivalid_q;
    assign bus.int_ack     = (state_q == ST_INTSVC);
    assign bus.int_active  = int_act_q;
    assign bus.ret_addr    = ret_q;
    assign bus.pc          = pc_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table, hand-written corner sequences, random program.
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic run;

    pc_seq_if #(.ADDR_W(12)) bus ();

    pc_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        int op;
        int jaddr;
        int ack_lat;
        int exp_pc;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_next(input int p, input int op, input int j);
        case (op)
            0:       return (p + 1) % 4096;
            1:       return (p + 2) % 4096;
            2:       return (p + 3) % 4096;
            default: return j % 4096;
        endcase
    endfunction

    // Entered while in FETCH; leaves in the first EXEC cycle.
    task automatic fetch_cycle(input int lat, input int exp_addr);
        chk("fetch_req", int'(bus.fetch_req), 1);
        chk("fetch_addr", int'(bus.fetch_addr), exp_addr);
        for (int i = 1; i < lat; i++) step();
        bus.fetch_ack = 1'b1;
        step();
        bus.fetch_ack = 1'b0;
        chk("instr_valid", int'(bus.instr_valid), 1);
        chk("exec_state", int'(bus.state), 2);
    endtask

    task automatic exec_instr(input int lat, input int op, input int j, input bit res);
        logic [1:0]  op_v;
        logic [11:0] j_v;
        op_v = 2'(op);
        j_v  = 12'(j);
        for (int i = 0; i < lat; i++) begin
            step();
            if (i == 0) chk("instr_valid_pulse", int'(bus.instr_valid), 0);
        end
        bus.pc_op     = op_v;
        bus.jump_addr = j_v;
        bus.resume    = res;
        bus.exec_done = 1'b1;
        step();
        bus.exec_done = 1'b0;
        bus.resume    = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mpc;
        int op, j, la, le;

        vecs[0] = '{0, 0,      3, 12'h801};
        vecs[1] = '{2, 0,      1, 12'h804};
        vecs[2] = '{3, 12'hAAA, 2, 12'hAAA};
        vecs[3] = '{1, 0,      1, 12'hAAC};
        vecs[4] = '{3, 12'hFFF, 1, 12'hFFF};
        vecs[5] = '{0, 0,      4, 12'h000};
        vecs[6] = '{3, 12'hFFF, 1, 12'hFFF};
        vecs[7] = '{1, 0,      1, 12'h001};
        vecs[8] = '{3, 12'hFFE, 2, 12'hFFE};
        vecs[9] = '{2, 0,      1, 12'h001};

        rst_n         = 1'b0;
        run           = 1'b0;
        bus.fetch_ack = 1'b0;
        bus.exec_done = 1'b0;
        bus.pc_op     = 2'd0;
        bus.jump_addr = 12'h0;
        bus.resume    = 1'b0;
        bus.int_req   = 1'b0;
        bus.int_id    = 3'd0;

        // Reset values and IDLE hold
        step(); step();
        rst_n = 1'b1;
        step(); step();
        chk("rst_state", int'(bus.state), 0);
        chk("rst_pc", int'(bus.pc), 12'h800);
        chk("rst_fetch_req", int'(bus.fetch_req), 0);
        chk("rst_instr_valid", int'(bus.instr_valid), 0);
        chk("rst_int_ack", int'(bus.int_ack), 0);
        chk("rst_int_active", int'(bus.int_active), 0);
        chk("rst_ret_addr", int'(bus.ret_addr), 0);

        run = 1'b1;
        step();
        chk("start_state", int'(bus.state), 1);
        chk("start_fetch_req", int'(bus.fetch_req), 1);
        chk("start_fetch_addr", int'(bus.fetch_addr), 12'h800);

        // exec_done outside EXEC is ignored
        bus.exec_done = 1'b1;
        bus.pc_op     = 2'd3;
        bus.jump_addr = 12'h123;
        step();
        bus.exec_done = 1'b0;
        chk("ign_exec_done_state", int'(bus.state), 1);
        chk("ign_exec_done_pc", int'(bus.pc), 12'h800);

        // Vector table: next-PC select and wrap cases
        mpc = 12'h800;
        for (int v = 0; v < 10; v++) begin
            fetch_cycle(vecs[v].ack_lat, mpc);
            if (v == 0) begin
                // fetch_ack outside FETCH is ignored
                bus.fetch_ack = 1'b1;
                step();
                bus.fetch_ack = 1'b0;
                chk("ign_fetch_ack_state", int'(bus.state), 2);
                chk("ign_fetch_ack_ivalid", int'(bus.instr_valid), 0);
            end
            exec_instr(0, vecs[v].op, vecs[v].jaddr, 1'b0);
            chk($sformatf("vec%0d_pc", v), int'(bus.pc), vecs[v].exp_pc);
            chk($sformatf("vec%0d_state", v), int'(bus.state), 1);
            mpc = vecs[v].exp_pc;
        end

        // Interrupt sequence from pc=0x810
        fetch_cycle(1, mpc);
        exec_instr(1, 3, 12'h810, 1'b0);
        mpc = 12'h810;
        chk("jump810_pc", int'(bus.pc), mpc);
`ifdef PC_SEQ_INTR_EN
        fetch_cycle(1, mpc);
        bus.int_req = 1'b1;
        bus.int_id  = 3'd2;
        exec_instr(0, 0, 0, 1'b0);
        chk("int_svc_state", int'(bus.state), 3);
        chk("int_ack_pulse", int'(bus.int_ack), 1);
        chk("int_pc_ret", int'(bus.pc), 12'h811);
        step();
        bus.int_id = 3'd5;
        chk("int_post_state", int'(bus.state), 1);
        chk("int_ack_drop", int'(bus.int_ack), 0);
        chk("int_ret_addr", int'(bus.ret_addr), 12'h811);
        chk("int_vector", int'(bus.fetch_addr), 12'h80C);
        chk("int_active_set", int'(bus.int_active), 1);
        fetch_cycle(2, 12'h80C);
        exec_instr(0, 0, 0, 1'b0);
        chk("no_nest_state", int'(bus.state), 1);
        chk("no_nest_pc", int'(bus.pc), 12'h80D);
        chk("no_nest_active", int'(bus.int_active), 1);
        bus.int_req = 1'b0;
        fetch_cycle(1, 12'h80D);
        exec_instr(1, 3, 12'h123, 1'b1);
        chk("resume_pc", int'(bus.pc), 12'h811);
        chk("resume_active", int'(bus.int_active), 0);
        chk("resume_state", int'(bus.state), 1);
        fetch_cycle(1, 12'h811);
        exec_instr(0, 0, 0, 1'b1);
        chk("resume_inactive_pc", int'(bus.pc), 12'h811);
        mpc = 12'h811;
`else
        fetch_cycle(1, mpc);
        bus.int_req = 1'b1;
        bus.int_id  = 3'd2;
        exec_instr(0, 0, 0, 1'b0);
        chk("noint_state", int'(bus.state), 1);
        chk("noint_ack", int'(bus.int_ack), 0);
        chk("noint_pc", int'(bus.pc), 12'h811);
        fetch_cycle(1, 12'h811);
        exec_instr(0, 0, 0, 1'b1);
        chk("noint_resume_pc", int'(bus.pc), 12'h812);
        chk("noint_active", int'(bus.int_active), 0);
        chk("noint_ret_addr", int'(bus.ret_addr), 0);
        bus.int_req = 1'b0;
        mpc = 12'h812;
`endif

        // run dropped mid-FETCH: fetch and execute still complete, then IDLE
        run = 1'b0;
        step(); step();
        chk("run0_fetch_hold", int'(bus.state), 1);
        fetch_cycle(1, mpc);
        exec_instr(2, 0, 0, 1'b0);
        mpc = ref_next(mpc, 0, 0);
        chk("run0_idle", int'(bus.state), 0);
        chk("run0_pc", int'(bus.pc), mpc);
        step();
        chk("run0_idle_hold", int'(bus.state), 0);
        run = 1'b1;
        step();
        chk("rerun_fetch_addr", int'(bus.fetch_addr), mpc);

        // Asynchronous reset mid-FETCH, applied between clock edges
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc", int'(bus.pc), 12'h800);
        chk("async_rst_req", int'(bus.fetch_req), 0);
        chk("async_rst_state", int'(bus.state), 0);
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_idle", int'(bus.state), 0);
        run = 1'b1;
        step();
        chk("post_rst_fetch_addr", int'(bus.fetch_addr), 12'h800);

        // Random program against the arithmetic PC model
        mpc = 12'h800;
        for (int n = 0; n < 150; n++) begin
            op = int'($urandom_range(0, 3));
            j  = int'($urandom_range(0, 4095));
            la = int'($urandom_range(1, 4));
            le = int'($urandom_range(0, 3));
`ifndef PC_SEQ_INTR_EN
            bus.int_req = 1'($urandom_range(0, 1));
            bus.int_id  = 3'($urandom_range(0, 7));
`endif
            fetch_cycle(la, mpc);
            exec_instr(le, op, j, 1'($urandom_range(0, 1) & 0));
            mpc = ref_next(mpc, op, j);
            chk("rand_pc", int'(bus.pc), mpc);
            chk("rand_state", int'(bus.state), 1);
            chk("rand_int_ack", int'(bus.int_ack), 0);
        end
        bus.int_req = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
